// File: rtl/cmult_rr_sched_if.sv
// Requester, multiplier and result signals of the round-robin complex-multiplier scheduler.
// The master side drives requests and the multiplier products. The slave side is the scheduler.
interface cmult_rr_sched_if #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int AWIDTH = 16,
  parameter int BWIDTH = 18
);
  localparam int PW = AWIDTH + BWIDTH + 1;

  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ*AWIDTH-1:0]      req_ar;
  logic [NREQ*AWIDTH-1:0]      req_ai;
  logic [NREQ*BWIDTH-1:0]      req_br;
  logic [NREQ*BWIDTH-1:0]      req_bi;

  logic signed [AWIDTH-1:0]    mult_ar;
  logic signed [AWIDTH-1:0]    mult_ai;
  logic signed [BWIDTH-1:0]    mult_br;
  logic signed [BWIDTH-1:0]    mult_bi;
  logic signed [PW-1:0]        mult_pr;
  logic signed [PW-1:0]        mult_pi;

  logic                        res_valid;
  logic [IDW-1:0]              res_id;
  logic signed [PW-1:0]        res_pr;
  logic signed [PW-1:0]        res_pi;

  modport master (
    output req_valid, req_ar, req_ai, req_br, req_bi, mult_pr, mult_pi,
    input  req_ready, mult_ar, mult_ai, mult_br, mult_bi,
    input  res_valid, res_id, res_pr, res_pi
  );

  modport slave (
    input  req_valid, req_ar, req_ai, req_br, req_bi, mult_pr, mult_pi,
    output req_ready, mult_ar, mult_ai, mult_br, mult_bi,
    output res_valid, res_id, res_pr, res_pi
  );
endinterface

// File: rtl/cmult_rr_sched.sv
// Round-robin scheduler that time-shares one external fixed-latency complex multiplier.
// A {valid,id} tag pipeline runs beside the multiplier, and the product is re-registered with its owner id.
module cmult_rr_sched #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int AWIDTH   = 16,
  parameter int BWIDTH   = 18,
  parameter int MULT_LAT = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  cmult_rr_sched_if.slave   bus,
  output logic              busy
);
  localparam int PW = AWIDTH + BWIDTH + 1;

  logic [IDW-1:0]           last_grant;
  logic [IDW-1:0]           grant_idx;
  logic                     grant_any;
  logic [NREQ-1:0]          grant_vec;

  logic signed [AWIDTH-1:0] sel_ar;
  logic signed [AWIDTH-1:0] sel_ai;
  logic signed [BWIDTH-1:0] sel_br;
  logic signed [BWIDTH-1:0] sel_bi;

  logic signed [AWIDTH-1:0] mult_ar_q;
  logic signed [AWIDTH-1:0] mult_ai_q;
  logic signed [BWIDTH-1:0] mult_br_q;
  logic signed [BWIDTH-1:0] mult_bi_q;

  logic [MULT_LAT:0]        tag_valid;
  logic [IDW-1:0]           tag_id [0:MULT_LAT];

  logic                     res_valid_q;
  logic [IDW-1:0]           res_id_q;
  logic signed [PW-1:0]     res_pr_q;
  logic signed [PW-1:0]     res_pi_q;

  // Two passes give the wrap: lanes above last_grant first, then from lane 0 up to last_grant.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    if (en && !rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_any && bus.req_valid[i] && (IDW'(i) > last_grant)) begin
          grant_any    = 1'b1;
          grant_idx    = IDW'(i);
          grant_vec[i] = 1'b1;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!grant_any && bus.req_valid[i] && (IDW'(i) <= last_grant)) begin
          grant_any    = 1'b1;
          grant_idx    = IDW'(i);
          grant_vec[i] = 1'b1;
        end
      end
    end
  end

  // The operand mux produces zero when nothing is granted, so idle cycles present zeros to the multiplier.
  always_comb begin
    sel_ar = '0;
    sel_ai = '0;
    sel_br = '0;
    sel_bi = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vec[i]) begin
        sel_ar = bus.req_ar[i*AWIDTH +: AWIDTH];
        sel_ai = bus.req_ai[i*AWIDTH +: AWIDTH];
        sel_br = bus.req_br[i*BWIDTH +: BWIDTH];
        sel_bi = bus.req_bi[i*BWIDTH +: BWIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= IDW'(NREQ - 1);
      mult_ar_q   <= '0;
      mult_ai_q   <= '0;
      mult_br_q   <= '0;
      mult_bi_q   <= '0;
      tag_valid   <= '0;
      for (int s = 0; s <= MULT_LAT; s++) begin
        tag_id[s] <= '0;
      end
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_pr_q    <= '0;
      res_pi_q    <= '0;
    end else begin
      if (grant_any) begin
        last_grant <= grant_idx;
      end
      mult_ar_q <= sel_ar;
      mult_ai_q <= sel_ai;
      mult_br_q <= sel_br;
      mult_bi_q <= sel_bi;

      // The last tag stage lines up with the product of the operands presented one cycle after the grant.
      tag_valid <= {tag_valid[MULT_LAT-1:0], grant_any};
      tag_id[0] <= grant_idx;
      for (int s = 1; s <= MULT_LAT; s++) begin
        tag_id[s] <= tag_id[s-1];
      end

      res_valid_q <= tag_valid[MULT_LAT];
      res_id_q    <= tag_id[MULT_LAT];
      if (tag_valid[MULT_LAT]) begin
        res_pr_q <= bus.mult_pr;
        res_pi_q <= bus.mult_pi;
      end
    end
  end

  assign bus.req_ready = grant_vec;
  assign bus.mult_ar   = mult_ar_q;
  assign bus.mult_ai   = mult_ai_q;
  assign bus.mult_br   = mult_br_q;
  assign bus.mult_bi   = mult_bi_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_pr    = res_pr_q;
  assign bus.res_pi    = res_pi_q;

  assign busy = (|tag_valid) | res_valid_q;
endmodule

// File: tb/tb_cmult_rr_sched.sv
// Bench for cmult_rr_sched: directed scenarios, a transaction-level model, and a 6-cycle multiplier stand-in.
module tb_cmult_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int AW   = 16;
  localparam int BW   = 18;
  localparam int LAT  = 6;
  localparam int PW   = AW + BW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  cmult_rr_sched_if #(.NREQ(NREQ), .IDW(IDW), .AWIDTH(AW), .BWIDTH(BW)) bus();

  cmult_rr_sched #(.NREQ(NREQ), .IDW(IDW), .AWIDTH(AW), .BWIDTH(BW), .MULT_LAT(LAT)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .bus  (bus),
    .busy (busy)
  );

  // External complex multiplier with a fixed latency: there is no enable and no reset.
  logic signed [PW-1:0] pp_pr [LAT];
  logic signed [PW-1:0] pp_pi [LAT];
  always @(posedge clk) begin
    pp_pr[0] <= $signed(bus.mult_ar) * $signed(bus.mult_br) - $signed(bus.mult_ai) * $signed(bus.mult_bi);
    pp_pi[0] <= $signed(bus.mult_ar) * $signed(bus.mult_bi) + $signed(bus.mult_ai) * $signed(bus.mult_br);
    for (int s = 1; s < LAT; s++) begin
      pp_pr[s] <= pp_pr[s-1];
      pp_pi[s] <= pp_pi[s-1];
    end
  end
  assign bus.mult_pr = pp_pr[LAT-1];
  assign bus.mult_pi = pp_pi[LAT-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint a_lane(input logic [NREQ*AW-1:0] v, input int i);
    logic signed [AW-1:0] t;
    t = v[i*AW +: AW];
    return longint'(t);
  endfunction

  function automatic longint b_lane(input logic [NREQ*BW-1:0] v, input int i);
    logic signed [BW-1:0] t;
    t = v[i*BW +: BW];
    return longint'(t);
  endfunction

  // Transaction model: a grant in cycle c books a result for cycle c+8. A reset drops every booked result.
  typedef struct {
    int     id;
    longint pr;
    longint pi;
  } res_t;

  res_t   sched [int];
  int     cyc    = 0;
  bit     chk_en = 1'b0;
  int     last_m = NREQ - 1;
  longint em_ar = 0, em_ai = 0, em_br = 0, em_bi = 0;
  longint held_pr = 0, held_pi = 0;
  int     g;
  int     eid;
  int     obs;
  bit     erv;
  bit     ebusy;
  longint exp_rdy;
  longint xar, xai, xbr, xbi;
  res_t   r;

  int     grant_log [$];
  int     rid_log   [$];
  longint rpr_log   [$];
  longint rpi_log   [$];

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      g = -1;
      if (!rst && en) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (g < 0 && bus.req_valid[(last_m + k) % NREQ]) g = (last_m + k) % NREQ;
        end
      end
      exp_rdy = (g >= 0) ? (longint'(1) << g) : 0;
      chk("req_ready", longint'(bus.req_ready), exp_rdy);
      chk("mult_ar", longint'(bus.mult_ar), em_ar);
      chk("mult_ai", longint'(bus.mult_ai), em_ai);
      chk("mult_br", longint'(bus.mult_br), em_br);
      chk("mult_bi", longint'(bus.mult_bi), em_bi);

      if (sched.exists(cyc)) begin
        r       = sched[cyc];
        erv     = 1'b1;
        eid     = r.id;
        held_pr = r.pr;
        held_pi = r.pi;
      end else begin
        erv = 1'b0;
        eid = 0;
      end
      chk("res_valid", longint'(bus.res_valid), longint'(erv));
      chk("res_id", longint'(bus.res_id), longint'(eid));
      chk("res_pr", longint'(bus.res_pr), held_pr);
      chk("res_pi", longint'(bus.res_pi), held_pi);

      ebusy = 1'b0;
      for (int s = cyc; s <= cyc + 7; s++) begin
        if (sched.exists(s)) ebusy = 1'b1;
      end
      chk("busy", longint'(busy), longint'(ebusy));

      if (bus.res_valid) begin
        rid_log.push_back(int'(bus.res_id));
        rpr_log.push_back(longint'(bus.res_pr));
        rpi_log.push_back(longint'(bus.res_pi));
      end
      if (bus.req_ready != '0) begin
        obs = -1;
        for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) obs = i;
        grant_log.push_back(obs);
      end

      if (rst) begin
        for (int s = cyc + 1; s <= cyc + 8; s++) begin
          if (sched.exists(s)) sched.delete(s);
        end
        last_m  = NREQ - 1;
        em_ar   = 0; em_ai = 0; em_br = 0; em_bi = 0;
        held_pr = 0;
        held_pi = 0;
      end else if (g >= 0) begin
        xar = a_lane(bus.req_ar, g);
        xai = a_lane(bus.req_ai, g);
        xbr = b_lane(bus.req_br, g);
        xbi = b_lane(bus.req_bi, g);
        sched[cyc + 8] = '{g, xar * xbr - xai * xbi, xar * xbi + xai * xbr};
        last_m = g;
        em_ar = xar; em_ai = xai; em_br = xbr; em_bi = xbi;
      end else begin
        em_ar = 0; em_ai = 0; em_br = 0; em_bi = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_lane(input int i, input int ar, input int ai, input int br, input int bi);
    bus.req_ar[i*AW +: AW] = ar[AW-1:0];
    bus.req_ai[i*AW +: AW] = ai[AW-1:0];
    bus.req_br[i*BW +: BW] = br[BW-1:0];
    bus.req_bi[i*BW +: BW] = bi[BW-1:0];
  endtask

  task automatic clear_logs();
    grant_log.delete();
    rid_log.delete();
    rpr_log.delete();
    rpi_log.delete();
  endtask

  int rv_cnt;

  initial begin
    bus.req_valid = '0;
    bus.req_ar    = '0;
    bus.req_ai    = '0;
    bus.req_br    = '0;
    bus.req_bi    = '0;
    rst = 1'b1;
    en  = 1'b0;
    step(1);
    chk_en = 1'b1;
    step(1);
    rst = 1'b0;
    en  = 1'b1;
    step(2);

    // Single operation on lane 2
    set_lane(2, 3, -2, 5, 7);
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", longint'(bus.req_ready), 4);
    step(1);
    bus.req_valid = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("single_busy", longint'(busy), 1);
      if (k == 8) begin
        chk("single_res_valid", longint'(bus.res_valid), 1);
        chk("single_res_id", longint'(bus.res_id), 2);
        chk("single_res_pr", longint'(bus.res_pr), 29);
        chk("single_res_pi", longint'(bus.res_pi), 11);
      end
    end
    @(negedge clk);
    chk("single_idle", longint'(busy), 0);

    // Full contention starting from a freshly reset pointer
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    clear_logs();
    for (int i = 0; i < NREQ; i++) set_lane(i, 100 * (i + 1), -(3 + i), 50 + i, -(20 * i + 1));
    bus.req_valid = 4'b1111;
    step(12);
    bus.req_valid = '0;
    step(10);
    chk("contention_grant_count", grant_log.size(), 12);
    chk("contention_res_count", rid_log.size(), 12);
    if (grant_log.size() == 12 && rid_log.size() == 12) begin
      for (int i = 0; i < 12; i++) begin
        chk("contention_grant", grant_log[i], i % 4);
        chk("contention_res_id", rid_log[i], i % 4);
      end
    end

    // Wrap and skip with only lanes 1 and 3 requesting
    clear_logs();
    bus.req_valid = 4'b1010;
    step(6);
    bus.req_valid = '0;
    step(10);
    chk("wrap_grant_count", grant_log.size(), 6);
    if (grant_log.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("wrap_grant", grant_log[i], (i % 2 == 0) ? 1 : 3);
    end

    // Enable gating: two grants, then en=0 while every lane stays valid
    clear_logs();
    bus.req_valid = 4'b1111;
    step(2);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("gate_ready", longint'(bus.req_ready), 0);
      step(1);
    end
    step(3);
    @(negedge clk);
    chk("gate_busy_low", longint'(busy), 0);
    chk("gate_res_count", rid_log.size(), 2);
    step(1);
    en = 1'b1;
    @(negedge clk);
    chk("gate_resume_ready", longint'(bus.req_ready), 4);
    step(1);
    bus.req_valid = '0;
    step(10);

    // Reset while three operations are in flight
    bus.req_valid = 4'b1111;
    step(3);
    bus.req_valid = '0;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    rv_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.res_valid) rv_cnt++;
      if (k == 0) begin
        chk("rst_res_pr", longint'(bus.res_pr), 0);
        chk("rst_res_pi", longint'(bus.res_pi), 0);
        chk("rst_res_id", longint'(bus.res_id), 0);
        chk("rst_mult_ar", longint'(bus.mult_ar), 0);
        chk("rst_busy", longint'(busy), 0);
      end
    end
    chk("rst_no_result", rv_cnt, 0);
    step(1);
    bus.req_valid = 4'b1111;
    @(negedge clk);
    chk("rst_first_grant", longint'(bus.req_ready), 1);
    step(1);
    bus.req_valid = '0;
    step(10);

    // Full-scale operands: products must come out at full precision
    clear_logs();
    set_lane(0, -32768, -32768, -131072, -131072);
    bus.req_valid = 4'b0001;
    step(1);
    set_lane(1, 32767, 32767, 131071, 131071);
    bus.req_valid = 4'b0010;
    step(1);
    set_lane(2, -32768, 32767, 131071, -131072);
    bus.req_valid = 4'b0100;
    step(1);
    bus.req_valid = '0;
    step(10);
    chk("ext_res_count", rpr_log.size(), 3);
    if (rpr_log.size() == 3) begin
      chk("ext0_pr", rpr_log[0], 0);
      chk("ext0_pi", rpi_log[0], 64'sd8589934592);
      chk("ext1_pr", rpr_log[1], 0);
      chk("ext1_pi", rpi_log[1], 64'sd8589606914);
      chk("ext2_pr", rpr_log[2], -64'sd98304);
      chk("ext2_pi", rpi_log[2], 64'sd8589770753);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end
endmodule

// File: doc/cmult_rr_sched.md
Name: cmult_rr_sched

Overview:
- Round-robin scheduler that time-shares one 3-DSP pipelined complex multiplier (cmult, fixed 6-cycle latency, no enable, no reset) between NREQ requesters.
- Each requester offers one complex operand pair per handshake.
- The block registers the granted operands onto the multiplier inputs and carries a valid/ID tag pipeline matched to the multiplier latency.
- It re-times the product into a tagged, registered result port broadcast to all requesters.

Parameters:
NREQ, 4, number of requesters (2..16)
IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ
AWIDTH, 16, width of the a operand (ar, ai)
BWIDTH, 18, width of the b operand (br, bi)
MULT_LAT, 6, multiplier latency in cycles, from operands presented to product valid

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  grant enable; 0 = no new grants, in-flight work drains
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester grant (one-hot or zero)
req_ar  in  NREQ*AWIDTH  flattened a-real; lane i at [i*AWIDTH +: AWIDTH]
req_ai  in  NREQ*AWIDTH  flattened a-imag
req_br  in  NREQ*BWIDTH  flattened b-real
req_bi  in  NREQ*BWIDTH  flattened b-imag
mult_ar  out  AWIDTH  registered operand to multiplier
mult_ai  out  AWIDTH  registered operand to multiplier
mult_br  out  BWIDTH  registered operand to multiplier
mult_bi  out  BWIDTH  registered operand to multiplier
mult_pr  in  AWIDTH+BWIDTH+1  multiplier real product
mult_pi  in  AWIDTH+BWIDTH+1  multiplier imag product
res_valid  out  1  result valid, single-cycle pulse per issued operation
res_id  out  IDW  requester index owning the result
res_pr  out  AWIDTH+BWIDTH+1  real product, signed
res_pi  out  AWIDTH+BWIDTH+1  imag product, signed
busy  out  1  high while any issued operation has not yet produced res_valid

Behaviour:
- Reset: req_ready=0 combinationally while rst=1. mult_*=0, res_valid=0, res_id=0, res_pr=0, res_pi=0, busy=0. Tag pipeline cleared. Round-robin pointer set so requester 0 has highest priority.
- Arbitration (combinational, per cycle): if en=1 and rst=0, grant the first requester with req_valid=1, searching from last_grant+1 mod NREQ upward with wrap. req_ready is one-hot on that lane, otherwise 0. At most one grant per cycle.
- Handshake: req_valid[i]&req_ready[i] in cycle T means operands accepted. On that edge, last_grant<=i, mult_*<=lane i operands, and tag stage0 <= {1,i}.
- Requesters may hold req_valid across cycles. Operands are sampled only on the handshake edge. req_valid deassertion without a grant is legal.
- No grant in a cycle: mult_* driven to 0, tag stage0 <= {0,0}.
- Tag pipeline: MULT_LAT+1 stages of {valid,id}, shifting every cycle; no stall. The last stage aligns with mult_pr/mult_pi for the operands presented in cycle T+1.
- Result: on the aligned edge, res_valid<=tag valid, res_id<=tag id, res_pr<=mult_pr, res_pi<=mult_pi. res_pr/res_pi update only when tag valid=1 and hold otherwise.
- Latency: handshake in cycle T gives res_valid=1 in cycle T+MULT_LAT+2 (T+8 at defaults). Throughput is one operation per cycle.
- No result backpressure. Consumers must accept res_valid whenever it asserts.
- Fairness: with all lanes continuously valid, grants rotate 0,1,..,NREQ-1,0. A lone valid requester is granted every cycle.
- en=0: no grants and pointer held. In-flight operations still complete. busy drops 1 cycle after the last res_valid.
- busy: OR of all tag-stage valids and the res_valid register.
- Reset mid-operation: all in-flight operations discarded. No res_valid for them, even though the multiplier still outputs their products.
- Arithmetic: the block does no arithmetic. Widths and signedness pass through unchanged.

Test Plan:
- Single op: lane 2 valid with ar=3, ai=-2, br=5, bi=7 at T -> req_ready=4'b0100 at T; res_valid at T+8 with res_id=2, res_pr=29, res_pi=11; busy high T+1..T+8.
- Full contention: all 4 lanes valid for 12 cycles, each with a distinct constant -> grant order 0,1,2,3,0,1,2,3,0,1,2,3; 12 back-to-back res_valid; res_id and products match in order.
- Wrap and skip: only lanes 1 and 3 valid, last_grant=3 -> grants alternate 1,3,1,3; lanes 0 and 2 are never granted.
- Enable gating: en=0 with all lanes valid for 5 cycles -> req_ready=0; in-flight results still emerge; busy falls to 0; with en=1, arbitration resumes from the held pointer.
- Reset mid-flight: issue 3 ops, assert rst for 1 cycle 2 cycles later -> no res_valid in the following 10 cycles; all outputs 0; the first grant goes to lane 0.
- Extremes: ar=ai=-32768, br=bi=-131072 and max-positive cases -> res_pr/res_pi equal full-precision products bit-exact; no truncation.
